branch_target_predictor: RTL and testbench

- Fetch-stage branch predictor, built as a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- IF gets a same-cycle taken/target prediction for the next-PC mux.
- EX writes back the resolved outcome to train the entry, and the block raises a registered mispredict/redirect to the PC and flush logic.
- Upstream of the 2-bit counter stage: it supplies each counter's update enable and resolved outcome, and consumes the counter's MSB as the prediction.

---
 rtl/branch_target_predictor_pkg.sv | 16 +
 rtl/branch_target_predictor_sat_ctr2_next.sv | 22 ++
 rtl/branch_target_predictor.sv | 110 +++++++++++
 tb/tb_branch_target_predictor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// Shared encodings for the branch target predictor: 2-bit counter states
// and the sequential-PC increment.
package branch_target_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t        CTR_RESET = WNT;
  localparam ctr_t        CTR_ALLOC = WT;
  localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/branch_target_predictor_sat_ctr2_next.sv
// Next-state logic for one 2-bit saturating direction counter.
module sat_ctr2_next
  import branch_target_predictor_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t next
);

  // step one state toward the resolved outcome, saturating at SNT and ST
  always_comb begin
    next = ctr;
    case (ctr)
      SNT:     next = taken ? WNT : SNT;
      WNT:     next = taken ? WT  : SNT;
      WT:      next = taken ? ST  : WNT;
      ST:      next = taken ? ST  : WT;
      default: next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters: same-cycle fetch lookup,
// EX-stage training, registered mispredict/redirect and saturating perf counters.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int ENTRIES = 1 << IDX_W;

  logic              valid_tab  [ENTRIES];
  logic [TAG_W-1:0]  tag_tab    [ENTRIES];
  logic [PC_W-1:0]   target_tab [ENTRIES];
  logic [1:0]        ctr_tab    [ENTRIES];

  logic [IDX_W-1:0]  l_idx;
  logic [TAG_W-1:0]  l_tag;
  logic [IDX_W-1:0]  e_idx;
  logic [TAG_W-1:0]  e_tag;
  logic              e_hit;
  logic              mis_cond;
  ctr_t              ctr_next;

  assign l_idx = if_pc[IDX_W+1:2];
  assign l_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign e_idx = ex_pc[IDX_W+1:2];
  assign e_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads registered state only, so an update to the same index shows next cycle.
  assign pred_hit    = valid_tab[l_idx] && (tag_tab[l_idx] == l_tag);
  assign pred_taken  = pred_hit && ctr_tab[l_idx][1];
  assign pred_target = pred_taken ? target_tab[l_idx] : (if_pc + PC_W'(PC_INC));

  assign e_hit    = valid_tab[e_idx] && (tag_tab[e_idx] == e_tag);
  assign mis_cond = ex_valid &&
                    ((ex_taken != ex_pred_taken) ||
                     (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));

  sat_ctr2_next u_ctr_next (
    .ctr   (ctr_t'(ctr_tab[e_idx])),
    .taken (ex_taken),
    .next  (ctr_next)
  );

  // table training: hit steps the counter, taken miss allocates over any occupant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_tab[i]  <= 1'b0;
        tag_tab[i]    <= '0;
        target_tab[i] <= '0;
        ctr_tab[i]    <= CTR_RESET;
      end
    end else if (ex_valid) begin
      if (e_hit) begin
        ctr_tab[e_idx] <= ctr_next;
        if (ex_taken) begin
          target_tab[e_idx] <= ex_target;
        end
      end else if (ex_taken) begin
        valid_tab[e_idx]  <= 1'b1;
        tag_tab[e_idx]    <= e_tag;
        target_tab[e_idx] <= ex_target;
        ctr_tab[e_idx]    <= CTR_ALLOC;
      end
    end
  end

  // redirect pulse and saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      mispredict <= mis_cond;
      if (ex_valid) begin
        redirect_pc <= ex_taken ? ex_target : (ex_pc + PC_W'(PC_INC));
        if (br_count != {CNT_W{1'b1}}) begin
          br_count <= br_count + CNT_W'(1);
        end
      end
      if (mis_cond && (mispred_count != {CNT_W{1'b1}})) begin
        mispred_count <= mispred_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed-vector bench for branch_target_predictor with hand-computed expectations.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = 32'h0;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = 32'h0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] br_count;
  logic [15:0] mispred_count;

  int vectors = 0;
  int miscompares = 0;

  branch_target_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  task automatic lookup(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  // one resolved branch for one cycle; returns at the following negedge
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    drive_ex(pc, tk, tgt, ptk, ptgt);
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    lookup(32'h0000_0100);
    vectors++; if (pred_hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit got=%h exp=0", pred_hit); end
    vectors++; if (pred_taken !== 1'b0) begin miscompares++; $display("FAIL reset_taken got=%h exp=0", pred_taken); end
    vectors++; if (pred_target !== 32'h0000_0104) begin miscompares++; $display("FAIL reset_target got=%h exp=00000104", pred_target); end
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL reset_mispredict got=%h exp=0", mispredict); end
    vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("FAIL reset_redirect got=%h exp=0", redirect_pc); end
    vectors++; if (br_count !== 16'h0 || mispred_count !== 16'h0) begin miscompares++; $display("FAIL reset_counts got=%h/%h exp=0/0", br_count, mispred_count); end
  endtask

  task automatic test_allocate;
    resolve(32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL alloc_mispredict got=%h exp=1", mispredict); end
    vectors++; if (redirect_pc !== 32'h0000_0200) begin miscompares++; $display("FAIL alloc_redirect got=%h exp=00000200", redirect_pc); end
    lookup(32'h0000_0100);
    vectors++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1) begin miscompares++; $display("FAIL alloc_hit_taken got=%h%h exp=11", pred_hit, pred_taken); end
    vectors++; if (pred_target !== 32'h0000_0200) begin miscompares++; $display("FAIL alloc_target got=%h exp=00000200", pred_target); end
    vectors++; if (br_count !== 16'd1 || mispred_count !== 16'd1) begin miscompares++; $display("FAIL alloc_counts got=%0d/%0d exp=1/1", br_count, mispred_count); end
    @(negedge clk);
    vectors++; if (mispredict !== 1'b0) begin miscompares++; $display("FAIL alloc_pulse_end got=%h exp=0", mispredict); end
  endtask

  task automatic test_counter;
    logic [4:0] outcome;
    logic [4:0] exp_taken;
    outcome   = 5'b00011;
    exp_taken = 5'b00111;
    for (int i = 0; i < 5; i++) begin
      resolve(32'h0000_0100, outcome[i], 32'h0000_0200, outcome[i], 32'h0000_0200);
      lookup(32'h0000_0100);
      vectors++; if (pred_taken !== exp_taken[i]) begin miscompares++; $display("FAIL ctr_step%0d got=%h exp=%h", i, pred_taken, exp_taken[i]); end
    end
    vectors++; if (pred_hit !== 1'b1 || pred_target !== 32'h0000_0104) begin miscompares++; $display("FAIL ctr_sat_nt got=%h/%h exp=1/00000104", pred_hit, pred_target); end
    vectors++; if (br_count !== 16'd6 || mispred_count !== 16'd1) begin miscompares++; $display("FAIL ctr_counts got=%0d/%0d exp=6/1", br_count, mispred_count); end
  endtask

  task automatic test_alias;
    resolve(32'h0000_0200, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0000_0300) begin miscompares++; $display("FAIL alias_redirect got=%h/%h exp=1/00000300", mispredict, redirect_pc); end
    lookup(32'h0000_0100);
    vectors++; if (pred_hit !== 1'b0 || pred_target !== 32'h0000_0104) begin miscompares++; $display("FAIL alias_old_miss got=%h/%h exp=0/00000104", pred_hit, pred_target); end
    lookup(32'h0000_0200);
    vectors++; if (pred_taken !== 1'b1 || pred_target !== 32'h0000_0300) begin miscompares++; $display("FAIL alias_new_hit got=%h/%h exp=1/00000300", pred_taken, pred_target); end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    drive_ex(32'h0000_0200, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0300);
    lookup(32'h0000_0200);
    vectors++; if (pred_target !== 32'h0000_0300) begin miscompares++; $display("FAIL same_cycle_old got=%h exp=00000300", pred_target); end
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    vectors++; if (pred_target !== 32'h0000_0400) begin miscompares++; $display("FAIL same_cycle_new got=%h exp=00000400", pred_target); end
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0000_0400) begin miscompares++; $display("FAIL same_cycle_redirect got=%h/%h exp=1/00000400", mispredict, redirect_pc); end
    vectors++; if (br_count !== 16'd8 || mispred_count !== 16'd3) begin miscompares++; $display("FAIL same_cycle_counts got=%0d/%0d exp=8/3", br_count, mispred_count); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive_ex(32'h0000_0140, 1'b1, 32'h0000_0500, 1'b0, 32'h0);
    @(negedge clk);
    drive_ex(32'h0000_0144, 1'b0, 32'h0000_0900, 1'b1, 32'h0000_0900);
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0000_0500) begin miscompares++; $display("FAIL b2b_first got=%h/%h exp=1/00000500", mispredict, redirect_pc); end
    @(negedge clk);
    ex_valid = 1'b0;
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0000_0148) begin miscompares++; $display("FAIL b2b_second got=%h/%h exp=1/00000148", mispredict, redirect_pc); end
    @(negedge clk);
    vectors++; if (mispredict !== 1'b0 || redirect_pc !== 32'h0000_0148) begin miscompares++; $display("FAIL b2b_idle got=%h/%h exp=0/00000148", mispredict, redirect_pc); end
    vectors++; if (br_count !== 16'd10 || mispred_count !== 16'd5) begin miscompares++; $display("FAIL b2b_counts got=%0d/%0d exp=10/5", br_count, mispred_count); end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    drive_ex(32'h0000_0180, 1'b1, 32'h0000_0600, 1'b0, 32'h0);
    @(negedge clk);
    drive_ex(32'h0000_0184, 1'b1, 32'h0000_0700, 1'b0, 32'h0);
    vectors++; if (mispredict !== 1'b1) begin miscompares++; $display("FAIL mid_pending got=%h exp=1", mispredict); end
    #2;
    rst = 1'b1;
    lookup(32'h0000_0200);
    vectors++; if (mispredict !== 1'b0 || redirect_pc !== 32'h0) begin miscompares++; $display("FAIL mid_async_clear got=%h/%h exp=0/0", mispredict, redirect_pc); end
    vectors++; if (br_count !== 16'h0 || mispred_count !== 16'h0) begin miscompares++; $display("FAIL mid_counts got=%h/%h exp=0/0", br_count, mispred_count); end
    vectors++; if (pred_hit !== 1'b0 || pred_target !== 32'h0000_0204) begin miscompares++; $display("FAIL mid_table_clear got=%h/%h exp=0/00000204", pred_hit, pred_target); end
    @(negedge clk);
    ex_valid = 1'b0;
    rst = 1'b0;
    lookup(32'h0000_0184);
    vectors++; if (pred_hit !== 1'b0 || pred_target !== 32'h0000_0188) begin miscompares++; $display("FAIL mid_no_update got=%h/%h exp=0/00000188", pred_hit, pred_target); end
    lookup(32'h0000_0180);
    vectors++; if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin miscompares++; $display("FAIL mid_prev_entry got=%h%h exp=00", pred_hit, pred_taken); end
  endtask

  task automatic test_saturate;
    @(negedge clk);
    drive_ex(32'h0000_0010, 1'b0, 32'h0, 1'b1, 32'h0000_0040);
    repeat (65534) @(negedge clk);
    vectors++; if (mispred_count !== 16'hFFFE || br_count !== 16'hFFFE) begin miscompares++; $display("FAIL sat_below got=%h/%h exp=fffe/fffe", mispred_count, br_count); end
    @(negedge clk);
    vectors++; if (mispred_count !== 16'hFFFF || br_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach got=%h/%h exp=ffff/ffff", mispred_count, br_count); end
    @(negedge clk);
    ex_valid = 1'b0;
    vectors++; if (mispred_count !== 16'hFFFF || br_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got=%h/%h exp=ffff/ffff", mispred_count, br_count); end
    vectors++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0000_0014) begin miscompares++; $display("FAIL sat_redirect got=%h/%h exp=1/00000014", mispredict, redirect_pc); end
  endtask

  initial begin
    test_reset;
    test_allocate;
    test_counter;
    test_alias;
    test_same_cycle;
    test_back_to_back;
    test_reset_midstream;
    test_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
